// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
package ps2_pkg;

    localparam int unsigned PS2_KEY_W = 66;
    localparam int unsigned PS2_ACC_W = 64;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    // PrtSc is the one extended key whose make/break is two extended codes.
    localparam logic [7:0] PS2_PRTSC_LO  = 8'h12;
    localparam logic [7:0] PS2_PRTSC_HI  = 8'h7C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_frame_state_e;

    // True for bytes that never end a sequence on their own.
    function automatic logic ps2_is_prefix(input logic [7:0] b);
        return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK) || (b == PS2_PFX_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises a raw PS/2 line, debounces it and emits a one-cycle
// strobe on each accepted falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic line_raw,
    output logic fall_strobe
);

    localparam int unsigned CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchroniser; the idle line level is high.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_raw;
            sync_q <= meta_q;
        end
    end

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            level_q     <= 1'b1;
            cnt_q       <= '0;
            fall_strobe <= 1'b0;
        end else begin
            fall_strobe <= 1'b0;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_q     <= sync_q;
                cnt_q       <= '0;
                fall_strobe <= ~sync_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// Receive-only PS/2 keyboard front end: frames bytes, assembles prefixed
// key sequences and publishes them on a toggle-flagged event bus.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 43000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ps2_clk_i,
    input  logic                 ps2_data_i,
    output logic [PS2_KEY_W-1:0] ps2_key,
    output logic                 ps2_err
);

    localparam int unsigned TMO_W = 16;
    localparam int unsigned BIT_W = 3;
    localparam int unsigned NUM_W = 4;

    logic                 strobe;
    logic                 data_meta_q;
    logic                 data_sync_q;

    ps2_frame_state_e     state_q;
    ps2_frame_state_e     state_d;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [7:0]           shreg_q;
    logic                 par_ok_q;
    logic [TMO_W-1:0]     tmo_q;

    logic                 byte_good_c;
    logic                 frame_err_c;
    logic                 timeout_c;

    logic [PS2_ACC_W-1:0] acc_q;
    logic [NUM_W-1:0]     n_q;
    logic                 pause_q;
    logic [PS2_ACC_W-1:0] key_q;
    logic                 tog_q;

    logic [PS2_ACC_W-1:0] acc_next_c;
    logic [NUM_W-1:0]     n_next_c;
    logic                 is_pause_c;
    logic                 complete_c;
    logic                 overflow_c;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .line_raw    (ps2_clk_i),
        .fall_strobe (strobe)
    );

    // Data line only needs synchronising; it is sampled on the clock strobe.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame next-state and byte/error decisions; a strobe beats a timeout.
    always_comb begin
        state_d     = state_q;
        byte_good_c = 1'b0;
        frame_err_c = 1'b0;
        timeout_c   = 1'b0;
        if (strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_sync_q) state_d = DATA;
                    else              frame_err_c = 1'b1;
                end
                DATA: begin
                    if (bit_cnt_q == BIT_W'(7)) state_d = PARITY;
                end
                PARITY: begin
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_sync_q && par_ok_q) byte_good_c = 1'b1;
                    else                         frame_err_c = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if ((state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
            timeout_c = 1'b1;
            state_d   = IDLE;
        end
    end

    // Frame datapath: shift register, bit count, parity and timeout counter.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
        end else begin
            if (strobe) begin
                unique case (state_q)
                    IDLE:    bit_cnt_q <= '0;
                    DATA: begin
                        shreg_q   <= {data_sync_q, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                    PARITY:  par_ok_q <= ^{shreg_q, data_sync_q};
                    default: ;
                endcase
            end
            if (strobe || timeout_c || (state_q == IDLE)) tmo_q <= '0;
            else                                         tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    // Decide whether the incoming good byte closes the current sequence.
    always_comb begin
        acc_next_c = (acc_q << 8) | PS2_ACC_W'(shreg_q);
        n_next_c   = n_q + NUM_W'(1);
        is_pause_c = pause_q || ((n_q == '0) && (shreg_q == PS2_PFX_PAUSE));
        complete_c = 1'b1;
        if (is_pause_c) begin
            complete_c = (n_next_c == NUM_W'(8));
        end else if (ps2_is_prefix(shreg_q)) begin
            complete_c = 1'b0;
        end else if ((n_q == NUM_W'(1)) && (acc_q[7:0] == PS2_PFX_EXT)
                     && (shreg_q == PS2_PRTSC_LO)) begin
            complete_c = 1'b0;
        end else if ((n_q == NUM_W'(2)) && (acc_q[15:0] == {PS2_PFX_EXT, PS2_PFX_BRK})
                     && (shreg_q == PS2_PRTSC_HI)) begin
            complete_c = 1'b0;
        end
        overflow_c = !complete_c && (n_next_c == NUM_W'(8));
    end

    // Sequence accumulator and event-bus publication.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            n_q     <= '0;
            pause_q <= 1'b0;
            key_q   <= '0;
            tog_q   <= 1'b0;
            ps2_err <= 1'b0;
        end else begin
            ps2_err <= 1'b0;
            if (frame_err_c || timeout_c) begin
                acc_q   <= '0;
                n_q     <= '0;
                pause_q <= 1'b0;
                ps2_err <= 1'b1;
            end else if (byte_good_c) begin
                if (complete_c) begin
                    key_q   <= acc_next_c;
                    tog_q   <= ~tog_q;
                    acc_q   <= '0;
                    n_q     <= '0;
                    pause_q <= 1'b0;
                end else if (overflow_c) begin
                    acc_q   <= '0;
                    n_q     <= '0;
                    pause_q <= 1'b0;
                    ps2_err <= 1'b1;
                end else begin
                    acc_q   <= acc_next_c;
                    n_q     <= n_next_c;
                    pause_q <= is_pause_c;
                end
            end
        end
    end

    assign ps2_key = {1'b0, tog_q, key_q};

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: randomized and directed PS/2 frames
// checked against a byte-list model of the sequence rules.
module tb_ps2_key_rx;

    localparam int unsigned FLEN = 8;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned HALF = 12;

    logic        clk_sys    = 1'b0;
    logic        reset      = 1'b1;
    logic        ps2_clk_i  = 1'b1;
    logic        ps2_data_i = 1'b1;
    logic [65:0] ps2_key;
    logic        ps2_err;

    ps2_key_rx #(
        .FILTER_LEN (FLEN),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_key    (ps2_key),
        .ps2_err    (ps2_err)
    );

    always #5 clk_sys = ~clk_sys;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    int          err_pending = 0;
    logic [7:0]  seq_q[$];
    logic        exp_tog  = 1'b0;
    logic [63:0] last_exp = '0;
    logic        prev_tog = 1'b0;

    // Monitor: every toggle of bit 64 and every error pulse is matched
    // against the expectations queued by the stimulus side.
    always @(negedge clk_sys) begin
        if (reset) begin
            prev_tog = 1'b0;
        end else begin
            if (ps2_key[64] != prev_tog) begin
                prev_tog = ps2_key[64];
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL key_unexpected got=%h", ps2_key);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({ps2_key[65], ps2_key[63:0]} !== {1'b0, e}) begin
                        bad++;
                        $display("FAIL key_value got=%h want=%h", {ps2_key[65], ps2_key[63:0]}, {1'b0, e});
                    end
                end
            end
            if (ps2_err) begin
                total++;
                if (err_pending == 0) begin
                    bad++;
                    $display("FAIL err_unexpected got=1 want=0");
                end else begin
                    err_pending--;
                end
            end
        end
    end

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Reference model: applies the sequence rules to the list of bytes seen.
    task automatic model_byte(input logic [7:0] b);
        logic        done;
        logic [63:0] v;
        seq_q.push_back(b);
        if (seq_q[0] == 8'hE1)                                         done = (seq_q.size() == 8);
        else if (b inside {8'hE0, 8'hF0, 8'hE1})                       done = 1'b0;
        else if (seq_q.size() == 2 && seq_q[0] == 8'hE0 && b == 8'h12) done = 1'b0;
        else if (seq_q.size() == 3 && seq_q[0] == 8'hE0 && seq_q[1] == 8'hF0 && b == 8'h7C)
                                                                       done = 1'b0;
        else                                                           done = 1'b1;
        if (done) begin
            v = '0;
            foreach (seq_q[i]) v = {v[55:0], seq_q[i]};
            exp_q.push_back(v);
            last_exp = v;
            exp_tog  = ~exp_tog;
            seq_q.delete();
        end else if (seq_q.size() == 8) begin
            err_pending++;
            seq_q.delete();
        end
    endtask

    task automatic send_bits(input logic [10:0] fr, input int count);
        for (int i = 0; i < count; i++) begin
            ps2_data_i = fr[i];
            wait_cyc(HALF);
            ps2_clk_i = 1'b0;
            wait_cyc(HALF);
            ps2_clk_i = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(fr, 11);
        ps2_data_i = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0);
    endtask

    task automatic send_bad(input logic [7:0] b);
        err_pending++;
        seq_q.delete();
        send_frame(b, 1'b1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || err_pending != 0) && k < 3000) begin
            wait_cyc(1);
            k++;
        end
        check({tag, "_keys_left"}, 66'(exp_q.size()), 66'(0));
        check({tag, "_errs_left"}, 66'(err_pending), 66'(0));
    endtask

    initial begin
        logic [7:0]  b;
        int          r;
        logic [10:0] fr;

        wait_cyc(4);
        check("reset_key", ps2_key, 66'(0));
        check("reset_err", 66'(ps2_err), 66'(0));
        reset = 1'b0;
        wait_cyc(4);

        send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h7C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h7C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        drain("sequences");

        send_bad(8'h1C);
        send_byte(8'h1C);
        drain("parity");

        // Partial frame: start bit plus four data bits, then the clock stops.
        err_pending++;
        seq_q.delete();
        fr = {1'b1, 1'b0, 8'h1C, 1'b0};
        send_bits(fr, 5);
        ps2_data_i = 1'b1;
        wait_cyc(TMO + 100);
        send_byte(8'h1C);
        drain("timeout");

        for (int i = 0; i < 8; i++) send_byte(8'hE0);
        drain("overflow");

        for (int i = 0; i < 6; i++) begin
            ps2_clk_i = 1'b0;
            wait_cyc(3);
            ps2_clk_i = 1'b1;
            wait_cyc(10);
        end
        wait_cyc(30);
        check("glitch_hold", ps2_key, {1'b0, exp_tog, last_exp});

        send_byte(8'hE0);
        wait_cyc(5);
        reset = 1'b1;
        seq_q.delete();
        exp_tog  = 1'b0;
        last_exp = '0;
        wait_cyc(3);
        check("midseq_reset_key", ps2_key, 66'(0));
        check("midseq_reset_err", 66'(ps2_err), 66'(0));
        reset = 1'b0;
        wait_cyc(4);
        send_byte(8'h75);
        drain("after_reset");

        for (int i = 0; i < 110; i++) begin
            r = $urandom_range(0, 99);
            b = 8'($urandom_range(0, 255));
            if (r < 6) begin
                send_bad(b);
            end else begin
                if (r < 26) begin
                    case ($urandom_range(0, 2))
                        0:       b = 8'hE0;
                        1:       b = 8'hF0;
                        default: b = 8'hE1;
                    endcase
                end else if (r < 34) begin
                    b = (r < 30) ? 8'h12 : 8'h7C;
                end
                send_byte(b);
            end
        end
        drain("random");
        check("final_key", ps2_key, {1'b0, exp_tog, last_exp});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
